// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared constants, state encoding and helpers for the SHA message padder
package sha_pkg;

    localparam logic [1:0] MODE_HASH = 2'd0;
    localparam logic [1:0] MODE_INIT = 2'd1;
    localparam logic [1:0] MODE_REDO = 2'd3;

    localparam int BLK_W     = 512;
    localparam int BLK_WORDS = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } pad_state_e;

    // Only a final word may be short; anything else (or an out-of-range count) counts as 4 bytes.
    function automatic logic [2:0] eff_nbytes(input logic [2:0] nbytes, input logic last);
        if (!last || nbytes > 3'd4) begin
            return 3'd4;
        end
        return nbytes;
    endfunction

endpackage

// File: rtl/sha_pad_bytes.sv
// rtl/sha_pad_bytes.sv - masks a word to its valid bytes and inserts the 0x80 terminator
module sha_pad_bytes
    import sha_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    input  logic [3:0]  idx,
    output logic [31:0] padded,
    output logic [6:0]  mark
);

    logic [31:0] keep_mask;
    logic [31:0] insert;

    always_comb begin
        keep_mask = '0;
        insert    = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(nbytes)) begin
                keep_mask[31-8*b -: 8] = 8'hFF;
            end else if (b == int'(nbytes)) begin
                insert[31-8*b -: 8] = 8'h80;
            end
        end
    end

    assign padded = (word & keep_mask) | insert;
    // Byte offset within the block where the 0x80 lands; 64 means it spills into the next block.
    assign mark   = {1'b0, idx, 2'b00} + {4'b0000, nbytes};

endmodule

// File: rtl/sha_msg_pad.sv
// rtl/sha_msg_pad.sv - packs 32-bit message words into padded 512-bit SHA-256 blocks
module sha_msg_pad
    import sha_pkg::*;
#(
    parameter int GAP = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    input  logic [2:0]       s_nbytes,
    output logic             blk_valid,
    output logic [1:0]       blk_mode,
    output logic [BLK_W-1:0] blk_message,
    output logic             blk_last
);

    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    pad_state_e    state;
    pad_state_e    state_nxt;
    logic [31:0]   words [BLK_WORDS];
    logic [3:0]    idx;
    logic [63:0]   bit_len;
    logic [63:0]   len_nxt;
    logic          first;
    logic          issue_last;
    logic          pad_pending;
    logic          pad_lead80;
    logic [GW-1:0] gap_cnt;
    logic          fire;
    logic [2:0]    nb_eff;
    logic [31:0]   word_pad;
    logic [6:0]    mark;

    assign fire    = s_valid & s_ready;
    assign nb_eff  = eff_nbytes(s_nbytes, s_last);
    assign len_nxt = bit_len + {58'd0, nb_eff, 3'd0};

    sha_pad_bytes u_pad_bytes (
        .word   (s_data),
        .nbytes (nb_eff),
        .idx    (idx),
        .padded (word_pad),
        .mark   (mark)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:  if (fire && (s_last || idx == 4'd15)) state_nxt = ST_ISSUE;
            ST_PAD:   state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (gap_cnt == '0) begin
                    if (issue_last)       state_nxt = ST_DRAIN;
                    else if (pad_pending) state_nxt = ST_PAD;
                    else                  state_nxt = ST_FILL;
                end
            end
            default:  state_nxt = ST_FILL;
        endcase
    end

    // Block assembly buffer; its contents only matter once a block is complete, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fire) begin
            if (!s_last) begin
                words[idx] <= s_data;
            end else begin
                for (int w = 0; w < BLK_WORDS; w++) begin
                    if (4'(w) == idx) begin
                        words[w] <= word_pad;
                    end else if (5'(w) == ({1'b0, idx} + 5'd1) && nb_eff == 3'd4) begin
                        words[w] <= 32'h8000_0000;
                    end else if (4'(w) > idx) begin
                        words[w] <= '0;
                    end
                end
                if (mark <= 7'd55) begin
                    words[14] <= len_nxt[63:32];
                    words[15] <= len_nxt[31:0];
                end
            end
        end else if (state == ST_PAD) begin
            for (int w = 1; w < 14; w++) begin
                words[w] <= '0;
            end
            words[0]  <= pad_lead80 ? 32'h8000_0000 : 32'h0;
            words[14] <= bit_len[63:32];
            words[15] <= bit_len[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_FILL;
            s_ready     <= 1'b0;
            idx         <= '0;
            bit_len     <= '0;
            first       <= 1'b1;
            issue_last  <= 1'b0;
            pad_pending <= 1'b0;
            pad_lead80  <= 1'b0;
            gap_cnt     <= '0;
            blk_valid   <= 1'b0;
            blk_mode    <= MODE_HASH;
            blk_message <= '0;
            blk_last    <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_ready   <= (state_nxt == ST_FILL);
            blk_valid <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            case (state)
                ST_FILL: begin
                    if (fire) begin
                        bit_len <= len_nxt;
                        idx     <= idx + 4'd1;
                        if (s_last) begin
                            issue_last  <= (mark <= 7'd55);
                            pad_pending <= (mark > 7'd55);
                            pad_lead80  <= (mark == 7'd64);
                        end else if (idx == 4'd15) begin
                            issue_last  <= 1'b0;
                            pad_pending <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    pad_pending <= 1'b0;
                    issue_last  <= 1'b1;
                end
                ST_ISSUE: begin
                    if (gap_cnt == '0) begin
                        blk_valid <= 1'b1;
                        blk_mode  <= first ? MODE_INIT : MODE_HASH;
                        blk_last  <= issue_last;
                        gap_cnt   <= GW'(GAP - 1);
                        for (int w = 0; w < BLK_WORDS; w++) begin
                            blk_message[BLK_W-1-32*w -: 32] <= words[w];
                        end
                        if (issue_last) begin
                            bit_len <= '0;
                            first   <= 1'b1;
                            idx     <= '0;
                        end else begin
                            first <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_pad.sv
// tb/tb_sha_msg_pad.sv - randomized and directed self-checking bench for sha_msg_pad
module tb_sha_msg_pad;

    localparam int GAP = 65;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_nbytes;
    logic         blk_valid;
    logic [1:0]   blk_mode;
    logic [511:0] blk_message;
    logic         blk_last;

    sha_msg_pad #(.GAP(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_nbytes    (s_nbytes),
        .blk_valid   (blk_valid),
        .blk_mode    (blk_mode),
        .blk_message (blk_message),
        .blk_last    (blk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] msg;
        logic [1:0]   mode;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   prev_cyc = 0;
    bit   have_prev = 0;
    bit   track = 0;
    bit   saw_low = 0;
    exp_t e_mon;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (track && !s_ready) saw_low = 1;
        if (!reset) begin
            have_prev = 0;
        end else if (blk_valid) begin
            strobe_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_block", 1, 0);
            end else begin
                e_mon = exp_q.pop_front();
                check("blk_message", blk_message, e_mon.msg);
                check("blk_mode", blk_mode, e_mon.mode);
                check("blk_last", blk_last, e_mon.last);
            end
            if (have_prev) check("gap_min", (cyc - prev_cyc) >= GAP, 1);
            prev_cyc  = cyc;
            have_prev = 1;
        end
    end

    task automatic push_exp(input logic [511:0] msg, input logic [1:0] mode, input logic last);
        exp_t e;
        e.msg = msg; e.mode = mode; e.last = last;
        exp_q.push_back(e);
    endtask

    // Reference padding: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length, split into blocks.
    task automatic model_msg(input logic [7:0] m[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nblk;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b+i];
            push_exp(blk, (b == 0) ? 2'd1 : 2'd0, b == nblk - 1);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [2:0] nb, input logic l);
        s_valid = 1'b1; s_data = d; s_nbytes = nb; s_last = l;
        for (int t = 0; ; t++) begin
            @(posedge clk);
            if (s_ready) break;
            if (t > 4000) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
    endtask

    // Bytes beyond the valid count in the last word are random so masking is exercised.
    task automatic send_msg(input logic [7:0] m[$], input bit extra_empty);
        int n;
        int nw;
        n = m.size();
        if (n == 0) begin
            drive_word($urandom, 3'd0, 1'b1);
            return;
        end
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int          nb;
            d  = $urandom;
            nb = (n - 4*w >= 4) ? 4 : n - 4*w;
            for (int b = 0; b < nb; b++) d[31-8*b -: 8] = m[4*w+b];
            drive_word(d, 3'(nb), (w == nw - 1) && !extra_empty);
        end
        if (extra_empty) drive_word($urandom, 3'd0, 1'b1);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
        check("blocks_issued", exp_q.size(), 0);
    endtask

    task automatic words_to_bytes(input logic [31:0] w[$], output logic [7:0] m[$]);
        m = {};
        foreach (w[i]) for (int b = 0; b < 4; b++) m.push_back(w[i][31-8*b -: 8]);
    endtask

    initial begin
        logic [7:0]   m[$];
        logic [7:0]   m2[$];
        logic [31:0]  wq[$];
        logic [511:0] blk;
        int           k;
        int           len;
        int           r;

        reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_mode", blk_mode, 0);
        check("rst_blk_message", blk_message, 0);
        check("rst_blk_last", blk_last, 0);
        reset = 1'b1;
        #1 check("ready_before_edge", s_ready, 0);
        @(posedge clk); #1;
        check("ready_after_reset", s_ready, 1);

        // "abc"
        push_exp({32'h61626380, 416'd0, 64'h18}, 2'd1, 1'b1);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        wait_done();

        // empty message
        push_exp({32'h80000000, 480'd0}, 2'd1, 1'b1);
        m = {};
        send_msg(m, 0);
        wait_done();

        // 56 bytes: terminator at offset 56 forces a length-only block
        wq = {};
        blk = '0;
        for (int w = 0; w < 14; w++) begin
            wq.push_back(32'hA0A00000 | 32'(w));
            blk[511-32*w -: 32] = 32'hA0A00000 | 32'(w);
        end
        blk[511-32*14 -: 32] = 32'h80000000;
        push_exp(blk, 2'd1, 1'b0);
        push_exp({448'd0, 64'h1C0}, 2'd0, 1'b1);
        words_to_bytes(wq, m);
        send_msg(m, 0);
        wait_done();

        // 64 bytes: data-only block then 0x80-led block, exactly GAP apart
        wq = {};
        blk = '0;
        for (int w = 0; w < 16; w++) begin
            wq.push_back(32'h5C000000 ^ (32'(w) * 32'h01010101));
            blk[511-32*w -: 32] = 32'h5C000000 ^ (32'(w) * 32'h01010101);
        end
        push_exp(blk, 2'd1, 1'b0);
        push_exp({32'h80000000, 416'd0, 64'h200}, 2'd0, 1'b1);
        k = strobe_q.size();
        words_to_bytes(wq, m);
        send_msg(m, 0);
        wait_done();
        if (strobe_q.size() >= k + 2) check("gap_exact", 512'(strobe_q[k+1] - strobe_q[k]), GAP);
        else check("gap_exact_strobes", strobe_q.size(), k + 2);

        // two back-to-back one-word messages
        push_exp({32'hDEADBEEF, 32'h80000000, 384'd0, 64'h20}, 2'd1, 1'b1);
        push_exp({32'h01234567, 32'h80000000, 384'd0, 64'h20}, 2'd1, 1'b1);
        m  = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        m2 = {8'h01, 8'h23, 8'h45, 8'h67};
        saw_low = 0;
        track = 1;
        send_msg(m, 0);
        send_msg(m2, 0);
        wait_done();
        track = 0;
        check("ready_dropped", saw_low, 1);

        // reset after word 7 of a message, then "abc"
        for (int w = 0; w < 8; w++) drive_word($urandom, 3'd4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_blk_message", blk_message, 0);
        check("midrst_s_ready", s_ready, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_exp({32'h61626380, 416'd0, 64'h18}, 2'd1, 1'b1);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 0);
        wait_done();

        // randomized messages with boundary-biased lengths
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      len = $urandom_range(52, 68);
            else if (r == 1) len = $urandom_range(0, 8);
            else             len = $urandom_range(0, 140);
            m = {};
            for (int j = 0; j < len; j++) m.push_back(8'($urandom));
            model_msg(m);
            send_msg(m, (len > 0) && (len % 4 == 0) && ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done();

        repeat (GAP + 10) @(negedge clk);
        check("leftover_blocks", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
